uart_tx_buffered: RTL and testbench

Buffered UART transmitter for the UART/SPI tile. It is the transmit counterpart to the existing UART receive path. It accepts bytes from the on-chip side through a valid/ready handshake into a small FIFO, then serialises them 8N1 (LSB first) onto `uart_tx_d_out`. The baud rate is selected at run time by `freq_control`. It sits between the command/SPI logic and the tile's TX pin, and it can drive the receiver's `uart_rx_d_in` directly in loopback.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_buffered.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  // freq_control encodings
  localparam logic [1:0] FREQ_9600   = 2'b00;
  localparam logic [1:0] FREQ_19200  = 2'b01;
  localparam logic [1:0] FREQ_57600  = 2'b10;
  localparam logic [1:0] FREQ_115200 = 2'b11;

  localparam int unsigned BAUD_CNT_W = 13;

  // Cycles per bit for the selected baud, truncated.
  function automatic logic [BAUD_CNT_W-1:0] baud_div(input int unsigned clock_freq,
                                                     input logic [1:0]  sel);
    int unsigned baud;
    case (sel)
      FREQ_9600:   baud = 9600;
      FREQ_19200:  baud = 19200;
      FREQ_57600:  baud = 57600;
      default:     baud = 115200;
    endcase
    return BAUD_CNT_W'(clock_freq / baud);
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data; pointers wrap modulo DEPTH.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: valid/ready byte FIFO feeding an LSB-first
// serialiser with run-time baud select. Define UART_TX_PARITY_EN to insert an
// even-parity bit between the data bits and the stop bit.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk_int,
  input  logic       uart_reset,
  input  logic [1:0] freq_control,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx_d_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]            fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;

  uart_tx_state_t        state_q;
  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BAUD_CNT_W-1:0] div_m1_q;
  logic [BAUD_CNT_W-1:0] div_m1_d;
  logic [2:0]            bit_q;
  logic [7:0]            shreg_q;
  logic                  line_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  bit_end;
`ifdef UART_TX_PARITY_EN
  logic                  par_q;
`endif

  assign tx_ready      = (fifo_count != CW'(FIFO_DEPTH));
  assign fifo_push     = tx_valid & ~fifo_full;
  assign bit_end       = (cnt_q == '0);
  assign fifo_pop      = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_end));
  assign div_m1_d      = baud_div(CLOCK_FREQ, freq_control) - 1'b1;
  assign uart_tx_d_out = line_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_int),
    .rst_ni  (uart_reset),
    .push_i  (fifo_push),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Frame sequencer: a pop (from IDLE or the last stop cycle) always starts a
  // new frame, which is what makes back-to-back frames gapless. tx_done is
  // registered one cycle early so it is high during the final stop cycle.
  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_m1_q <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      line_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (fifo_pop) begin
        state_q  <= START;
        line_q   <= 1'b0;
        busy_q   <= 1'b1;
        shreg_q  <= fifo_data;
        bit_q    <= '0;
        div_m1_q <= div_m1_d;
        cnt_q    <= div_m1_d;
`ifdef UART_TX_PARITY_EN
        par_q    <= ^fifo_data;
`endif
      end else begin
        unique case (state_q)
          IDLE: begin
            line_q <= 1'b1;
            busy_q <= 1'b0;
          end
          START: begin
            if (bit_end) begin
              state_q <= DATA;
              line_q  <= shreg_q[0];
              shreg_q <= shreg_q >> 1;
              cnt_q   <= div_m1_q;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              cnt_q <= div_m1_q;
              if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_q <= PARITY;
                line_q  <= par_q;
`else
                state_q <= STOP;
                line_q  <= 1'b1;
                done_q  <= (div_m1_q == '0);
`endif
              end else begin
                bit_q   <= bit_q + 3'd1;
                line_q  <= shreg_q[0];
                shreg_q <= shreg_q >> 1;
              end
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (bit_end) begin
              state_q <= STOP;
              line_q  <= 1'b1;
              cnt_q   <= div_m1_q;
              done_q  <= (div_m1_q == '0);
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
`endif
          STOP: begin
            if (bit_end) begin
              state_q <= IDLE;
              line_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cnt_q  <= cnt_q - 1'b1;
              done_q <= (cnt_q == BAUD_CNT_W'(1));
            end
          end
          default: begin
            state_q <= IDLE;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: a frame-level reference model
// (expected byte queue + ideal bit timeline) checks the serial line cycle by
// cycle. Honours UART_TX_PARITY_EN when defined.
`timescale 1ns/1ps
module tb_uart_tx_buffered;

  localparam int unsigned CLK_HZ = 1_152_000;
  localparam int unsigned DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif

  logic       clk_int;
  logic       uart_reset;
  logic [1:0] freq_control;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx_d_out;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_buffered #(
    .CLOCK_FREQ (CLK_HZ),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_int       (clk_int),
    .uart_reset    (uart_reset),
    .freq_control  (freq_control),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .uart_tx_d_out (uart_tx_d_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  initial clk_int = 1'b0;
  always #5 clk_int = ~clk_int;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Cycles per bit straight from the baud table.
  function automatic int unsigned div_of(input logic [1:0] sel);
    int unsigned baud;
    baud = (sel == 2'd0) ? 9600 : (sel == 2'd1) ? 19200 : (sel == 2'd2) ? 57600 : 115200;
    return CLK_HZ / baud;
  endfunction

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
  } frame_t;

  frame_t      exp_q[$];
  time         start_t[$];
  int unsigned pushed = 0;
  int unsigned popped = 0;

  // Monitor state
  bit          mon_active = 1'b0;
  frame_t      cur;
  int unsigned mon_k, mon_len, mon_idx;
  logic [NB-1:0] mon_bits;
  logic [NB-1:0] mon_seen;
  int unsigned line_err, done_err, busy_err;
  int unsigned idle_err   = 0;
  int unsigned unexpected = 0;
  logic        mon_prev_line = 1'b1;

  // Frame monitor: compares the line against the ideal bit timeline of the
  // frame at the head of the expected queue.
  always @(negedge clk_int) begin
    if (!uart_reset) begin
      if (uart_tx_d_out !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idle_err++;
      mon_active = 1'b0;
      exp_q.delete();
      pushed = 0;
      popped = 0;
    end else begin
      if (!mon_active) begin
        if (uart_tx_d_out === 1'b0) begin
          if (exp_q.size() > 0) begin
            cur        = exp_q.pop_front();
            popped++;
            mon_active = 1'b1;
            mon_k      = 0;
            mon_len    = NB * cur.div;
            mon_bits   = '0;
            mon_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) mon_bits[1 + i] = cur.data[i];
`ifdef UART_TX_PARITY_EN
            mon_bits[9] = ^cur.data;
`endif
            mon_bits[NB-1] = 1'b1;
            mon_seen = '0;
            line_err = 0;
            done_err = 0;
            busy_err = 0;
            start_t.push_back($time);
          end else if (mon_prev_line === 1'b1) begin
            unexpected++;
          end
        end else if (tx_busy !== 1'b0 || tx_done !== 1'b0) begin
          idle_err++;
        end
      end
      if (mon_active) begin
        mon_idx = mon_k / cur.div;
        if (uart_tx_d_out !== mon_bits[mon_idx]) line_err++;
        if (tx_done !== (mon_k == mon_len - 1)) done_err++;
        if (tx_busy !== 1'b1) busy_err++;
        if ((mon_k % cur.div) == cur.div / 2) mon_seen[mon_idx] = uart_tx_d_out;
        mon_k++;
        if (mon_k == mon_len) begin
          mon_active = 1'b0;
          check_val("frame_byte", 32'(mon_seen[8:1]), 32'(cur.data));
`ifdef UART_TX_PARITY_EN
          check_val("parity_bit", 32'(mon_seen[9]), 32'(^cur.data));
`endif
          check_val("stop_bit", 32'(mon_seen[NB-1]), 32'd1);
          check_val("line_cycle_errs", line_err, 0);
          check_val("done_cycle_errs", done_err, 0);
          check_val("busy_cycle_errs", busy_err, 0);
        end
      end
    end
    mon_prev_line = uart_tx_d_out;
  end

  task automatic tick();
    @(negedge clk_int);
    #1;
  endtask

  // One cycle of tx_valid; the model accepts only when the FIFO has room.
  task automatic drive_write(input logic [7:0] d, input int unsigned div);
    logic exp_ready;
    exp_ready = ((pushed - popped) < DEPTH);
    check_val("tx_ready", 32'(tx_ready), 32'(exp_ready));
    tx_valid = 1'b1;
    tx_data  = d;
    if (exp_ready) begin
      exp_q.push_back('{data: d, div: div});
      pushed++;
    end
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < budget) begin
      tick();
      n++;
    end
    check_val("drain_in_budget", 32'(exp_q.size() == 0 && !mon_active), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_w;
    int unsigned n, sel_div;
    logic [1:0] sel;

    uart_reset   = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = '0;
    freq_control = 2'b00;
    #2 uart_reset = 1'b0;

    // Reset held for 4 cycles
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("rst_line",  32'(uart_tx_d_out), 32'd1);
      check_val("rst_ready", 32'(tx_ready),      32'd1);
      check_val("rst_busy",  32'(tx_busy),       32'd0);
      check_val("rst_done",  32'(tx_done),       32'd0);
    end
    uart_reset = 1'b1;
    tick();
    tick();

    // Single byte at 9600-equivalent
    freq_control = 2'b00;
    start_t.delete();
    t_w = $time;
    drive_write(8'hA9, div_of(2'b00));
    wait_drain(NB * 120 + 50);
    check_val("single_starts", start_t.size(), 1);
    if (start_t.size() >= 1) check_val("single_latency", 32'(start_t[0] - (t_w - 1)), 32'd20);
`ifdef UART_TX_PARITY_EN
    drive_write(8'h07, div_of(2'b00));
    wait_drain(NB * 120 + 50);
`endif
    tick();

    // Back-to-back burst while idle; sixth byte must be dropped
    freq_control = 2'b01;
    start_t.delete();
    for (int i = 0; i < 6; i++) begin
      check_val("b2b_ready", 32'(tx_ready), 32'(i < 5));
      drive_write(8'(i + 1), div_of(2'b01));
    end
    wait_drain(5 * NB * 60 + 100);
    check_val("b2b_starts", start_t.size(), 5);
    for (int i = 1; i < 5; i++) begin
      if (start_t.size() > i) check_val("b2b_gap", 32'(start_t[i] - start_t[i-1]), NB * 60 * 10);
    end

    // Baud switch mid-frame affects only the queued frame
    freq_control = 2'b11;
    start_t.delete();
    drive_write(8'h55, div_of(2'b11));
    drive_write(8'h33, div_of(2'b00));
    for (int i = 0; i < 30; i++) tick();
    freq_control = 2'b00;
    wait_drain(NB * 130 + 100);
    check_val("baud_starts", start_t.size(), 2);
    if (start_t.size() >= 2) check_val("baud_first_len", 32'(start_t[1] - start_t[0]), NB * 10 * 10);

    // Randomized rounds at a fixed baud per round
    for (int r = 0; r < 6; r++) begin
      sel          = 2'($urandom_range(1, 3));
      sel_div      = div_of(sel);
      freq_control = sel;
      n            = $urandom_range(3, 6);
      for (int a = 0; a < 2 * n; a++) begin
        if ($urandom_range(0, 2) != 0) drive_write(8'($urandom), sel_div);
        else tick();
      end
      wait_drain(8 * NB * sel_div + 200);
    end

    // Reset mid-frame with two bytes queued
    freq_control = 2'b10;
    drive_write(8'h00, div_of(2'b10));
    drive_write(8'h11, div_of(2'b10));
    drive_write(8'h22, div_of(2'b10));
    for (int i = 0; i < 50; i++) tick();
    check_val("pre_reset_line", 32'(uart_tx_d_out), 32'd0);
    uart_reset = 1'b0;
    #1;
    check_val("async_reset_line", 32'(uart_tx_d_out), 32'd1);
    check_val("async_reset_busy", 32'(tx_busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    uart_reset = 1'b1;
    for (int i = 0; i < 3 * NB * 20; i++) tick();
    check_val("post_reset_ready", 32'(tx_ready), 32'd1);
    check_val("post_reset_busy",  32'(tx_busy),  32'd0);

    check_val("idle_errs", idle_err, 0);
    check_val("unexpected_frames", unexpected, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
